// File: rtl/core_types_pkg.sv
// Shared types and decode helpers for the memory-access stage.
package core_types_pkg;

  // Memory-stage FSM: StBusy means a bus request is outstanding.
  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mem_state_t;

  // funct3 access-size codes; anything else decodes as a word.
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  typedef enum logic [1:0] {
    SizeByte,
    SizeHalf,
    SizeWord
  } mem_size_t;

  // Registered outputs handed to write_back.
  typedef struct packed {
    logic        valid;
    logic        rmem;
    logic        wreg;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] mem_out;
    logic        misaligned;
    logic        bus_error;
  } memory_access_out_t;

  // Captured memory op, held for the whole bus transaction.
  typedef struct packed {
    logic        rmem;
    logic        wmem;
    logic        wreg;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic mem_size_t decode_size(input logic [2:0] funct3);
    mem_size_t size;
    case (funct3)
      Funct3Lb, Funct3Lbu: size = SizeByte;
      Funct3Lh, Funct3Lhu: size = SizeHalf;
      default:             size = SizeWord;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SizeHalf: mis = addr_lo[0];
      SizeWord: mis = |addr_lo;
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] store_be(input mem_size_t size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SizeByte: be = 4'b0001 << addr_lo;
      SizeHalf: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  be = 4'b1111;
    endcase
    return be;
  endfunction

  // Sub-word stores replicate the operand so the byte enables alone pick the lane.
  function automatic logic [31:0] store_wdata(input mem_size_t size, input logic [31:0] data);
    logic [31:0] wdata;
    case (size)
      SizeByte: wdata = {4{data[7:0]}};
      SizeHalf: wdata = {2{data[15:0]}};
      default:  wdata = data;
    endcase
    return wdata;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/half of a load word and sign- or zero-extends it.
module load_formatter
  import core_types_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  mem_size_t   size;
  logic        sign_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select then extension; funct3[2] set means unsigned.
  always_comb begin
    size     = decode_size(funct3_i);
    sign_ext = ~funct3_i[2];
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size)
      SizeByte: data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SizeHalf: data_o = {{16{sign_ext & half_sel[15]}}, half_sel};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: passes ALU ops through, runs one data-bus transaction per load/store,
// flags misaligned accesses and bus timeouts.
module memory_access
  import core_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        valid_in,
  input  logic        Rmem,
  input  logic        Wmem,
  input  logic        Wreg,
  input  logic [2:0]  funct3,
  input  logic [31:0] result,
  input  logic [31:0] storeData,
  input  logic [4:0]  rd,
  output logic        stall,
  output logic        valid_out,
  output logic        Rmem_o,
  output logic        Wreg_o,
  output logic [31:0] result_o,
  output logic [31:0] memOut,
  output logic [4:0]  rd_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  mem_state_t         state_q, state_d;
  mem_req_t           req_q, req_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  memory_access_out_t out_q, out_d;

  mem_size_t   in_size;
  logic        in_mis;
  logic        busy;
  logic [31:0] load_data;

  assign busy = (state_q == StBusy);

  load_formatter u_load_formatter (
    .rdata_i  (dmem_rdata),
    .addr_lo_i(req_q.result[1:0]),
    .funct3_i (req_q.funct3),
    .data_o   (load_data)
  );

  // Next-state: accept in idle, complete on ack or timeout in busy.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    out_d   = '0;
    in_size = decode_size(funct3);
    in_mis  = is_misaligned(in_size, result[1:0]);

    case (state_q)
      StIdle: begin
        if (valid_in) begin
          if (!(Rmem || Wmem)) begin
            out_d.valid  = 1'b1;
            out_d.rmem   = Rmem;
            out_d.wreg   = Wreg;
            out_d.rd     = rd;
            out_d.result = result;
          end else if (in_mis) begin
            out_d.valid      = 1'b1;
            out_d.rmem       = Rmem;
            out_d.rd         = rd;
            out_d.result     = result;
            out_d.misaligned = 1'b1;
          end else begin
            req_d.rmem   = Rmem;
            req_d.wmem   = Wmem;
            req_d.wreg   = Wreg;
            req_d.funct3 = funct3;
            req_d.rd     = rd;
            req_d.result = result;
            req_d.be     = store_be(in_size, result[1:0]);
            req_d.wdata  = store_wdata(in_size, storeData);
            cnt_d        = '0;
            state_d      = StBusy;
          end
        end
      end
      StBusy: begin
        out_d.rmem   = req_q.rmem;
        out_d.rd     = req_q.rd;
        out_d.result = req_q.result;
        if (dmem_ack) begin
          out_d.valid   = 1'b1;
          out_d.wreg    = req_q.wreg;
          out_d.mem_out = req_q.rmem ? load_data : 32'h0;
          state_d       = StIdle;
        end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
          out_d.valid     = 1'b1;
          out_d.bus_error = 1'b1;
          cnt_d           = '0;
          state_d         = StIdle;
        end else begin
          out_d.rmem   = 1'b0;
          out_d.rd     = '0;
          out_d.result = '0;
          cnt_d        = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign stall      = busy;
  assign dmem_req   = busy;
  assign dmem_we    = busy & req_q.wmem;
  assign dmem_addr  = busy ? {req_q.result[31:2], 2'b00} : 32'h0;
  assign dmem_be    = busy ? req_q.be : 4'b0000;
  assign dmem_wdata = busy ? req_q.wdata : 32'h0;

  assign valid_out  = out_q.valid;
  assign Rmem_o     = out_q.rmem;
  assign Wreg_o     = out_q.wreg;
  assign rd_o       = out_q.rd;
  assign result_o   = out_q.result;
  assign memOut     = out_q.mem_out;
  assign misaligned = out_q.misaligned;
  assign bus_error  = out_q.bus_error;

endmodule

// File: tb/tb_memory_access.sv
// Randomized bench for memory_access against a transaction-level reference model.
module tb_memory_access;

  localparam int MaxWait = 16;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        valid_in, Rmem, Wmem, Wreg;
  logic [2:0]  funct3;
  logic [31:0] result, storeData;
  logic [4:0]  rd;
  logic        stall, valid_out, Rmem_o, Wreg_o;
  logic [31:0] result_o, memOut;
  logic [4:0]  rd_o;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic        misaligned, bus_error;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] mem [256];

  memory_access #(.MAX_WAIT(MaxWait)) dut (
    .Clock(Clock), .Reset(Reset), .valid_in(valid_in), .Rmem(Rmem), .Wmem(Wmem),
    .Wreg(Wreg), .funct3(funct3), .result(result), .storeData(storeData), .rd(rd),
    .stall(stall), .valid_out(valid_out), .Rmem_o(Rmem_o), .Wreg_o(Wreg_o),
    .result_o(result_o), .memOut(memOut), .rd_o(rd_o), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .misaligned(misaligned),
    .bus_error(bus_error)
  );

  always #5 Clock = ~Clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes.
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [31:0] exp_be(input int sz, input int off);
    return ((32'd1 << sz) - 32'd1) << off;
  endfunction

  function automatic logic [31:0] exp_wdata(input int sz, input logic [31:0] d);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] word, input int off,
                                           input logic [2:0] f3);
    int          sz;
    logic [31:0] v, mask;
    sz   = size_of(f3);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (word >> (8 * off)) & mask;
    if (sz != 4 && f3[2] == 1'b0 && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic clear_inputs();
    valid_in = 0; Rmem = 0; Wmem = 0; Wreg = 0; funct3 = 0;
    result = 0; storeData = 0; rd = 0;
  endtask

  // Present one op at a negedge and follow it to completion; ack_delay is the BUSY
  // cycle in which the bench acks (beyond MaxWait means never).
  task automatic run_op(input logic rm, input logic wm, input logic wr, input logic [2:0] f3,
                        input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rdi,
                        input int ack_delay);
    int  sz, off, k, idx;
    bit  is_mem, mis, done;
    logic [31:0] ebe, ewd, eload;
    sz     = size_of(f3);
    off    = int'(res % 4);
    idx    = int'(res[9:2]);
    is_mem = rm | wm;
    mis    = is_mem && ((res % sz) != 0);
    ebe    = exp_be(sz, off);
    ewd    = exp_wdata(sz, sd);
    valid_in = 1; Rmem = rm; Wmem = wm; Wreg = wr; funct3 = f3;
    result = res; storeData = sd; rd = rdi;
    @(negedge Clock);
    clear_inputs();
    if (!is_mem || mis) begin
      check_eq("imm_valid", valid_out, 1);
      check_eq("imm_result", result_o, res);
      check_eq("imm_rd", rd_o, rdi);
      check_eq("imm_rmem", Rmem_o, rm);
      check_eq("imm_wreg", Wreg_o, wr & !mis);
      check_eq("imm_memout", memOut, 0);
      check_eq("imm_misaligned", misaligned, mis);
      check_eq("imm_buserr", bus_error, 0);
      check_eq("imm_req", dmem_req, 0);
      check_eq("imm_stall", stall, 0);
    end else begin
      k    = 1;
      done = 0;
      while (!done) begin
        check_eq("busy_stall", stall, 1);
        check_eq("busy_req", dmem_req, 1);
        check_eq("busy_addr", dmem_addr, {res[31:2], 2'b00});
        check_eq("busy_be", {28'h0, dmem_be}, ebe);
        check_eq("busy_we", dmem_we, wm);
        if (wm) check_eq("busy_wdata", dmem_wdata, ewd);
        check_eq("busy_valid", valid_out, 0);
        // Upstream keeps pushing; a stalled stage must ignore it.
        valid_in = 1'($urandom); Rmem = 1'($urandom); Wmem = 1'($urandom);
        Wreg = 1'($urandom); funct3 = 3'($urandom); result = $urandom;
        storeData = $urandom; rd = 5'($urandom);
        if (k == ack_delay) begin
          dmem_ack   = 1;
          dmem_rdata = wm ? $urandom : mem[idx];
        end
        eload = exp_load(mem[idx], off, f3);
        @(negedge Clock);
        dmem_ack = 0;
        clear_inputs();
        if (k == ack_delay) begin
          check_eq("done_valid", valid_out, 1);
          check_eq("done_stall", stall, 0);
          check_eq("done_wreg", Wreg_o, wr);
          check_eq("done_rmem", Rmem_o, rm);
          check_eq("done_rd", rd_o, rdi);
          check_eq("done_result", result_o, res);
          check_eq("done_memout", memOut, rm ? eload : 32'h0);
          check_eq("done_flags", {misaligned, bus_error}, 0);
          if (wm) begin
            for (int b = 0; b < 4; b++)
              if (ebe[b]) mem[idx][8*b +: 8] = ewd[8*b +: 8];
          end
          done = 1;
        end else if (k == MaxWait) begin
          check_eq("tmo_buserr", bus_error, 1);
          check_eq("tmo_valid", valid_out, 1);
          check_eq("tmo_wreg", Wreg_o, 0);
          check_eq("tmo_stall", stall, 0);
          check_eq("tmo_misaligned", misaligned, 0);
          done = 1;
        end
        k++;
      end
    end
  endtask

  initial begin
    int kind, sz, dly;
    logic [2:0]  f3;
    logic [31:0] res;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    clear_inputs();
    dmem_ack   = 0;
    dmem_rdata = 0;
    Reset      = 1;
    repeat (2) @(negedge Clock);
    Reset = 0;
    check_eq("rst_ctrl", {valid_out, stall, dmem_req, dmem_we, Rmem_o, Wreg_o,
                          misaligned, bus_error}, 0);
    check_eq("rst_result", result_o, 0);
    check_eq("rst_memout", memOut, 0);
    check_eq("rst_rd", rd_o, 0);
    check_eq("rst_bus", dmem_addr | dmem_wdata | {28'h0, dmem_be}, 0);

    // Directed cases.
    run_op(0, 0, 1, 3'b000, 32'h1234, 0, 5, 0);
    mem[64] = 32'h80FF_FF7F;
    run_op(1, 0, 1, 3'b000, 32'h103, 0, 7, 2);
    check_eq("lb_memout_const", exp_load(32'h80FF_FF7F, 3, 3'b000), 32'hFFFF_FF80);
    run_op(0, 1, 0, 3'b001, 32'h202, 32'hABCD, 0, 1);
    run_op(1, 0, 1, 3'b010, 32'h101, 0, 9, 1);
    run_op(1, 0, 1, 3'b010, 32'h100, 0, 3, 1000);
    run_op(1, 0, 1, 3'b010, 32'h104, 0, 4, MaxWait);

    // Reset while BUSY, then a stale ack.
    valid_in = 1; Rmem = 1; Wreg = 1; funct3 = 3'b010; result = 32'h108; rd = 6;
    @(negedge Clock);
    clear_inputs();
    check_eq("rstbusy_req_before", dmem_req, 1);
    Reset = 1;
    @(negedge Clock);
    Reset      = 0;
    check_eq("rstbusy_req", dmem_req, 0);
    check_eq("rstbusy_valid", valid_out, 0);
    check_eq("rstbusy_stall", stall, 0);
    dmem_ack   = 1;
    dmem_rdata = $urandom;
    @(negedge Clock);
    dmem_ack = 0;
    check_eq("rstbusy_ack_valid", valid_out, 0);
    check_eq("rstbusy_ack_req", dmem_req, 0);

    // Random traffic with stray acks while idle.
    for (int n = 0; n < 250; n++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        dmem_ack   = 1'($urandom);
        dmem_rdata = $urandom;
        @(negedge Clock);
        dmem_ack = 0;
        check_eq("idle_valid", valid_out, 0);
        check_eq("idle_req", dmem_req, 0);
      end
      kind = $urandom_range(0, 2);
      f3   = 3'($urandom);
      sz   = size_of(f3);
      res  = {22'($urandom), 10'($urandom)};
      if (kind != 0 && $urandom_range(0, 3) != 0) res = res & ~(32'(sz) - 32'd1);
      case ($urandom_range(0, 9))
        0:       dly = MaxWait + 3;
        1:       dly = MaxWait;
        default: dly = $urandom_range(1, 5);
      endcase
      run_op(kind == 1, kind == 2, 1'($urandom), f3, res, $urandom, 5'($urandom), dly);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16, meaning the number of BUSY cycles without dmem_ack before a bus timeout.
REQ-002 SHALL have port Clock  input  1  the single clock, rising edge.
REQ-003 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid_in  input  1  an execute-stage instruction is present.
REQ-005 SHALL have ports Rmem, Wmem, Wreg  input  1 each  load, store and register-write flags from execute.
REQ-006 SHALL have port funct3  input  3  access size and sign.
REQ-007 SHALL have ports result, storeData  input  32 each  ALU result (the address for memory ops) and the store operand.
REQ-008 SHALL have port rd  input  5  destination register.
REQ-009 SHALL have port stall  output  1  back-pressure to the upstream stages.
REQ-010 SHALL have ports valid_out, Rmem_o, Wreg_o  output  1 each  registered outputs to write_back.
REQ-011 SHALL have ports result_o, memOut  output  32 each; and rd_o  output  5.
REQ-012 SHALL have ports dmem_req, dmem_we  output  1 each; dmem_addr  output  32; dmem_be  output  4; dmem_wdata  output  32.
REQ-013 SHALL have ports dmem_rdata  input  32 and dmem_ack  input  1.
REQ-014 SHALL have ports misaligned, bus_error  output  1 each  single-cycle fault pulses.

Function
REQ-015 SHALL implement an FSM with states IDLE and BUSY; stall SHALL be 1 exactly when the state is BUSY.
REQ-016 SHALL accept an instruction when valid_in=1 and stall=0.
REQ-017 An accepted non-memory op (Rmem=0, Wmem=0) SHALL appear on the outputs next cycle with valid_out=1 and memOut=0.
REQ-018 An accepted aligned memory op SHALL be captured into a request register and SHALL move the FSM to BUSY.
REQ-019 In BUSY, dmem_req SHALL be 1, and dmem_addr, dmem_be, dmem_we and dmem_wdata SHALL be held stable until dmem_ack.
REQ-020 dmem_addr SHALL equal {result[31:2],2'b00}, and dmem_we SHALL equal Wmem.
REQ-021 Sizes SHALL be decoded from funct3: 000 byte, 001 half, 010 word, 100 unsigned byte, 101 unsigned half; any other code SHALL be treated as word.
REQ-022 For stores, dmem_be SHALL select the addressed lanes, and dmem_wdata SHALL replicate the byte or half across all lanes.
REQ-023 For loads, memOut SHALL be the addressed byte or half, right-justified, and sign- or zero-extended according to funct3.
REQ-024 When dmem_ack=1 in BUSY, the completed op SHALL be registered to the outputs with valid_out=1 next cycle, and the FSM SHALL return to IDLE.
REQ-025 Memory-op latency SHALL be (ack cycle - accept cycle) + 1, with a minimum of 2 cycles.
REQ-026 valid_out SHALL be 0 in every cycle in which no op completes.
REQ-027 dmem_ack SHALL be ignored while IDLE.
REQ-028 Misalignment SHALL be detected as half with result[0]=1, or word with result[1:0]!=0.
REQ-029 A misaligned op SHALL issue no bus request and SHALL complete next cycle with valid_out=1, Wreg_o=0 and a one-cycle misaligned=1 pulse.
REQ-030 After MAX_WAIT BUSY cycles without ack, the op SHALL be aborted: return to IDLE, valid_out=1, Wreg_o=0, and a one-cycle bus_error=1 pulse.
REQ-031 The timeout counter SHALL clear on each acceptance into BUSY.
REQ-032 Rmem_o, Wreg_o, rd_o and result_o SHALL carry the captured op's values, except where REQ-029 or REQ-030 force Wreg_o=0.

Reset
REQ-033 While Reset=1 at a rising edge, the FSM SHALL go to IDLE, and all outputs and the timeout counter SHALL be 0 the next cycle.
REQ-034 Reset asserted in BUSY SHALL drop dmem_req the next cycle; a later dmem_ack SHALL be ignored, and no valid_out SHALL be produced for the aborted op.

Structure
REQ-035 The mem_state_t enum, the funct3 size constants and a memory_access_out_t struct SHALL reside in core_types_pkg.
REQ-036 Load extraction and sign extension SHALL be a combinational sub-module named load_formatter.

Verification
REQ-037 ADD result=0x1234, rd=5 -> next cycle valid_out=1, result_o=0x1234, rd_o=5, Wreg_o=1, stall=0.
REQ-038 LB result=0x103, dmem_rdata=0x80FF_FF7F, ack two cycles after acceptance -> dmem_addr=0x100, memOut=0xFFFF_FF80, stall=1 for exactly 2 cycles.
REQ-039 SH result=0x202, storeData=0xABCD -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1.
REQ-040 LW result=0x101 -> dmem_req stays 0; next cycle misaligned=1, Wreg_o=0, valid_out=1.
REQ-041 LW with dmem_ack held 0 and MAX_WAIT=16 -> bus_error=1 after 16 BUSY cycles, FSM returns to IDLE.
REQ-042 Reset asserted in BUSY, then ack the following cycle -> dmem_req=0 and valid_out=0 throughout.
